// File: rtl/nandy_fetch.sv
// nandy_fetch: instruction fetch/sequencer feeding the control decoder.
// Fetches one byte per instruction from program memory into the instruction
// register, then runs one execute cycle (inst[7]=0) or two (inst[7]=1).
// The program counter is incremented at fetch and reloaded by datapath jumps.
//
// Optional feature: define NANDY_FETCH_HALT_EN to add the halt/halted ports
// and the HALT state.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_addr     program memory address (always pc)
//   mem_rd       program read request (FETCH only)
//   mem_data     program read data, mem_valid qualifies it
//   jump         pc load request, sampled in last execute cycle
//   jump_addr    jump target
//   inst         instruction register to decoder
//   cycle        execute sub-cycle to decoder
//   inst_valid   high in execute states
//   pc           program counter (points at next instruction while executing)
//   halt/halted  (optional) stop after current instruction / halted status
module nandy_fetch #(
    parameter int unsigned ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
`ifdef NANDY_FETCH_HALT_EN
    input  logic              halt,
    output logic              halted,
`endif
    output logic [7:0]        inst,
    output logic              cycle,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC0,
        EXEC1
`ifdef NANDY_FETCH_HALT_EN
        , HALT
`endif
    } state_t;

    state_t            state;
    state_t            nextState;
    state_t            doneState;
    logic [ADDR_W-1:0] pcNext;
    logic [7:0]        instNext;
    logic              memRdNext;
    logic              instValidNext;
    logic              cycleNext;
`ifdef NANDY_FETCH_HALT_EN
    logic              haltedNext;
`endif

    assign mem_addr = pc;

    // State register; status outputs are registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= 8'h00;
            mem_rd     <= 1'b1;
            inst_valid <= 1'b0;
            cycle      <= 1'b0;
`ifdef NANDY_FETCH_HALT_EN
            halted     <= 1'b0;
`endif
        end else begin
            state      <= nextState;
            pc         <= pcNext;
            inst       <= instNext;
            mem_rd     <= memRdNext;
            inst_valid <= instValidNext;
            cycle      <= cycleNext;
`ifdef NANDY_FETCH_HALT_EN
            halted     <= haltedNext;
`endif
        end
    end

    // Next-state, pc/inst update and output decode
    always_comb begin
        nextState = state;
        pcNext    = pc;
        instNext  = inst;

        // Where the last execute cycle goes once the instruction retires
`ifdef NANDY_FETCH_HALT_EN
        doneState = halt ? HALT : FETCH;
`else
        doneState = FETCH;
`endif

        case (state)
            FETCH: begin
                if (mem_valid) begin
                    instNext  = mem_data;
                    pcNext    = pc + ADDR_W'(1);
                    nextState = EXEC0;
                end
            end
            EXEC0: begin
                if (inst[7]) begin
                    nextState = EXEC1;
                end else begin
                    if (jump) pcNext = jump_addr;
                    nextState = doneState;
                end
            end
            EXEC1: begin
                if (jump) pcNext = jump_addr;
                nextState = doneState;
            end
`ifdef NANDY_FETCH_HALT_EN
            HALT: begin
                if (!halt) nextState = FETCH;
            end
`endif
            default: nextState = FETCH;
        endcase

        memRdNext     = (nextState == FETCH);
        instValidNext = (nextState == EXEC0) || (nextState == EXEC1);
        cycleNext     = (nextState == EXEC1);
`ifdef NANDY_FETCH_HALT_EN
        haltedNext    = (nextState == HALT);
`endif
    end

endmodule

// File: doc/nandy_fetch.md
Name: nandy_fetch

Overview:
- Instruction fetch/sequencer feeding the control decoder: reads instruction bytes from program memory, holds them in an instruction register, and drives the decoder's `inst` and `cycle` inputs.
- Instructions with inst[7]=1 get two execute cycles (cycle=0 then cycle=1). All others get one (cycle=0).
- Owns the program counter and applies jump targets supplied by the datapath.

Parameters:
- ADDR_W, 16, program counter / program memory address width.
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  program memory address; always equals pc.
- mem_rd  out  1  program read request.
- mem_data  in  8  program memory read data.
- mem_valid  in  1  mem_data valid this cycle; ignored unless mem_rd=1.
- jump  in  1  datapath requests PC load; sampled only in the last execute cycle.
- jump_addr  in  ADDR_W  jump target.
- inst  out  8  instruction register, to decoder.
- cycle  out  1  execute sub-cycle, to decoder.
- inst_valid  out  1  high in execute states (decoder outputs meaningful).
- pc  out  ADDR_W  program counter, already pointing at next instruction while executing.

Behaviour:
- States: FETCH, EXEC0, EXEC1 (plus HALT if the optional feature is enabled). All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.
- Reset (asynchronous, any state, including mid-fetch): state=FETCH, pc=RESET_PC, inst=8'h00, cycle=0, inst_valid=0. A pending memory read is abandoned.
- FETCH:
  - Outputs: mem_rd=1, inst_valid=0, cycle=0.
  - Waits any number of cycles for mem_valid.
  - On mem_valid=1: inst<=mem_data, pc<=pc+1 (mod 2^ADDR_W; 0xFFFF wraps to 0x0000), go to EXEC0.
  - Minimum fetch latency is 1 cycle when mem_valid is already high.
- EXEC0:
  - Outputs: mem_rd=0, inst_valid=1, cycle=0.
  - If inst[7]=1: go to EXEC1; jump is ignored in this state.
  - Else: if jump=1, pc<=jump_addr; go to FETCH.
- EXEC1:
  - Outputs: mem_rd=0, inst_valid=1, cycle=1.
  - If jump=1, pc<=jump_addr; go to FETCH.
- Jump has priority over the increment only in the sense that the increment already happened at fetch. A jump to the current pc value is legal and is simply reloaded.
- mem_valid outside FETCH is ignored. No request is issued in execute states, leaving the memory bus free for the data access signalled by the decoder (MC).
- Throughput:
  - 1-cycle instruction: 2 clocks minimum (FETCH+EXEC0).
  - 2-cycle instruction: 3 clocks minimum.
- inst holds its value through FETCH until new data is latched, so the decoder input never glitches.

Optional Feature:
- Macro NANDY_FETCH_HALT_EN.
- Enabled:
  - Adds ports `halt` (in, 1) and `halted` (out, 1).
  - If halt=1 in the last execute cycle (EXEC0 for inst[7]=0, EXEC1 for inst[7]=1), the jump/pc update still applies, but the next state is HALT instead of FETCH.
  - HALT outputs: mem_rd=0, inst_valid=0, halted=1, cycle=0.
  - HALT exits to FETCH on the first cycle halt=0.
  - halt asserted during FETCH takes effect only after the fetched instruction executes.
  - Reset clears halted to 0.
- Disabled: ports absent; HALT state not generated.

Test Plan:
- Reset with RESET_PC=16'h0100, release, hold mem_valid=1 with mem_data=8'h05 -> mem_addr=0x0100 and mem_rd=1 in the first cycle; next cycle inst=0x05, cycle=0, inst_valid=1, pc=0x0101; following cycle back in FETCH at 0x0101.
- mem_data=8'h83 -> cycle sequence 0,1 over two inst_valid cycles; jump=1 with jump_addr=0x2000 during cycle=0 is ignored, and during cycle=1 it loads pc=0x2000 and the next mem_addr=0x2000.
- mem_valid held low 3 cycles in FETCH -> mem_rd stays 1, inst unchanged and inst_valid=0 for 3 cycles; latched on the 4th cycle.
- pc=0xFFFF fetch of 8'h01 -> pc=0x0000 in EXEC0; jump=1 with jump_addr=0xFFFF -> next mem_addr=0xFFFF.
- Assert rst_n=0 mid-FETCH and again mid-EXEC1 -> outputs immediately (asynchronously) return to reset values; the first fetch after release is at RESET_PC.
- (NANDY_FETCH_HALT_EN) halt=1 during EXEC0 of 8'h02 -> halted=1 and mem_rd=0 for as long as halt is held; halt=0 -> FETCH resumes at the next pc.
